wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the data width of each register.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the number of architectural registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 31, meaning the index hardwired to zero (XZR).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 The block SHALL have port RegWrite, input, 1, the write-back enable.
REQ-007 The block SHALL have port WriteRegister, input, 5, the destination register index.
REQ-008 The block SHALL have port WriteData, input, WIDTH, the write-back value.
REQ-009 The block SHALL have port ReadRegister1, input, 5, the read port 1 index.
REQ-010 The block SHALL have port ReadRegister2, input, 5, the read port 2 index.
REQ-011 The block SHALL have port ReadData1, output, WIDTH, the read port 1 value.
REQ-012 The block SHALL have port ReadData2, output, WIDTH, the read port 2 value.
REQ-013 The block SHALL have port WriteCount, output, 16, the number of committed non-XZR writes since reset.

Function
REQ-014 Write path: a 5-to-32 decoder gated by RegWrite SHALL produce one-hot enables; register k SHALL capture WriteData at the rising clk edge iff RegWrite=1 and WriteRegister=k.
REQ-015 The write latency SHALL be one cycle, and the new value SHALL be architecturally visible from the following cycle onward.
REQ-016 Register ZERO_REG SHALL never be written; a write addressed to it SHALL be dropped silently and SHALL NOT increment WriteCount.
REQ-017 ReadData1 and ReadData2 SHALL be combinational, selected from the register array by ReadRegister1 and ReadRegister2 respectively.
REQ-018 A read of ZERO_REG SHALL return 0 regardless of any concurrent write.
REQ-019 Same-cycle bypass: if RegWrite=1, WriteRegister equals ReadRegisterN, and that index is not ZERO_REG, then ReadDataN SHALL equal WriteData in the same cycle.
REQ-020 Both read ports MAY address the same register, and both SHALL return identical values, including under bypass.
REQ-021 When RegWrite=0, the WriteRegister and WriteData inputs SHALL have no effect.
REQ-022 WriteCount SHALL increment by 1 per committed write, SHALL wrap from 0xFFFF to 0x0000, and SHALL NOT saturate.
REQ-023 Only registers 0..NREGS-1 exist; no index aliasing SHALL occur.

Reset
REQ-024 While reset=1 at a rising edge, all registers and WriteCount SHALL clear to 0.
REQ-025 Reset SHALL have priority over a simultaneous write, and that write SHALL be lost.
REQ-026 The bypass path SHALL be disabled while reset=1, so that ReadDataN reflects the register contents and is 0 after the first reset edge.
REQ-027 Reset asserted mid-operation SHALL take effect at the next edge, with no partial state retained.

Structure
REQ-028 A shared package regfile_pkg SHALL hold WIDTH, NREGS, ZERO_REG, and an address-width constant AW=5.
REQ-029 The write-enable decoder SHALL be a sub-module named decoder5_32 (5-bit index plus enable in, 32-bit one-hot out); read selection SHALL be built from the existing mux primitives.
REQ-030 The register array SHALL be a packed [NREGS-1:0][WIDTH-1:0] array.

Verification
REQ-031 Reset, then read all 32 indices -> all ReadData = 0 and WriteCount = 0.
REQ-032 Write X5=64'hDEADBEEF_00000001 and X6=64'd26000 on consecutive cycles, then read X5 and X6 -> the values match, and WriteCount = 2.
REQ-033 Write X31=64'd128, then read X31 on both ports -> 0, and WriteCount is unchanged.
REQ-034 RegWrite=1, WriteRegister=7, WriteData=64'd256, ReadRegister1=ReadRegister2=7 in the same cycle -> both ReadData = 256 before the edge.
REQ-035 Write X3=64'd64357 while reset=1 -> X3 reads 0 after the edge.
REQ-036 Perform 65536 writes to X1 -> WriteCount wraps to 0, and X1 holds the last value written.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the write-back register file: data width, register
// count, the hardwired-zero index and the register address width.
package regfile_pkg;

    localparam int WIDTH    = 64;
    localparam int NREGS    = 32;
    localparam int ZERO_REG = 31;
    localparam int AW       = 5;

endpackage

// File: rtl/decoder5_32.sv
// Enable-gated 5-to-32 decoder producing the one-hot register write enables.
module decoder5_32 (
    input  logic [4:0]  idx,
    input  logic        en,
    output logic [31:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Two-read, one-write register file with a hardwired zero register,
// same-cycle write-to-read bypass and a committed-write counter.
module wb_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH    = regfile_pkg::WIDTH,
    parameter int NREGS    = regfile_pkg::NREGS,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [AW-1:0]    WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [AW-1:0]    ReadRegister1,
    input  logic [AW-1:0]    ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic [15:0]      WriteCount
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [31:0]                 wr_en;
    logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [15:0]                 write_count_q, write_count_d;
    logic                        commit;
    logic                        bypass_en;

    decoder5_32 u_decoder (
        .idx    (WriteRegister),
        .en     (RegWrite),
        .onehot (wr_en)
    );

    // Bypass never applies during reset, so reads show the (cleared) array.
    assign bypass_en = RegWrite && !reset;
    assign commit    = RegWrite && (WriteRegister != ZERO_IDX)
                       && (int'(WriteRegister) < NREGS);

    always_comb begin
        // NOTE: every _d gets a default first so this block can never infer a latch.
        regs_d        = regs_q;
        write_count_d = write_count_q;
        for (int k = 0; k < NREGS; k++) begin
            if (wr_en[k] && (k != ZERO_REG)) begin
                regs_d[k] = WriteData;
            end
        end
        if (commit) begin
            write_count_d = write_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is a flop bank rather than a RAM, so clearing it here is intended.
            regs_q        <= '0;
            write_count_q <= '0;
        end else begin
            // NOTE: sequential state uses <= only so every flop samples pre-edge values.
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    function automatic logic [WIDTH-1:0] read_mux(
        input logic [AW-1:0]                 idx,
        input logic [NREGS-1:0][WIDTH-1:0]   regs,
        input logic                          byp,
        input logic [AW-1:0]                 widx,
        input logic [WIDTH-1:0]              wdata
    );
        logic [WIDTH-1:0] val;
        val = '0;
        if ((idx != ZERO_IDX) && (int'(idx) < NREGS)) begin
            if (byp && (idx == widx)) begin
                val = wdata;
            end else begin
                val = regs[idx];
            end
        end
        return val;
    endfunction

    assign ReadData1  = read_mux(ReadRegister1, regs_q, bypass_en, WriteRegister, WriteData);
    assign ReadData2  = read_mux(ReadRegister2, regs_q, bypass_en, WriteRegister, WriteData);
    assign WriteCount = write_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard-driven bench for wb_regfile: expected values are queued as
// stimulus is applied and compared when the outputs are sampled at negedge.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic [15:0] WriteCount;

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WriteCount    (WriteCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;   // 0: ReadData1, 1: ReadData2, 2: WriteCount
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [63:0] obs;
    int          checks   = 0;
    int          failures = 0;

    logic [63:0] model_regs [32];
    logic [15:0] model_count;

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            0:       return ReadData1;
            1:       return ReadData2;
            default: return {48'd0, WriteCount};
        endcase
    endfunction

    // Expected read value given the currently driven inputs and the model.
    function automatic logic [63:0] exp_read(input logic [4:0] r);
        if (r == 5'd31) return 64'd0;
        if (!reset && RegWrite && (r == WriteRegister)) return WriteData;
        return model_regs[r];
    endfunction

    task automatic drive(input logic rw, input logic [4:0] widx, input logic [63:0] wdata,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite      = rw;
        WriteRegister = widx;
        WriteData     = wdata;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
    endtask

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
            model_count = 16'd0;
        end else if (RegWrite && (WriteRegister != 5'd31)) begin
            model_regs[WriteRegister] = WriteData;
            model_count = model_count + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
            sb.push_back('{"reset_rd1", 0, 64'd0});
            sb.push_back('{"reset_rd2", 1, 64'd0});
            if (i == 0) sb.push_back('{"reset_count", 2, 64'd0});
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.sel);
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s idx=%0d: got %h expected %h", e.name, i, obs, e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd5, 64'hDEADBEEF_00000001, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd6, 64'd26000, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd6);
        sb.push_back('{"wr_x5", 0, 64'hDEADBEEF_00000001});
        sb.push_back('{"wr_x6", 1, 64'd26000});
        sb.push_back('{"wr_count", 2, 64'd2});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd31, 64'd128, 5'd31, 5'd31);
        sb.push_back('{"xzr_pre_rd1", 0, 64'd0});
        sb.push_back('{"xzr_pre_rd2", 1, 64'd0});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
        drive(1'b0, 5'd0, 64'd0, 5'd31, 5'd31);
        sb.push_back('{"xzr_post_rd1", 0, 64'd0});
        sb.push_back('{"xzr_post_rd2", 1, 64'd0});
        sb.push_back('{"xzr_count", 2, 64'd2});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd7, 64'd256, 5'd7, 5'd7);
        sb.push_back('{"byp_rd1", 0, 64'd256});
        sb.push_back('{"byp_rd2", 1, 64'd256});
        sb.push_back('{"byp_count_pre", 2, 64'd2});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
        drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd5);
        sb.push_back('{"byp_x7_held", 0, 64'd256});
        sb.push_back('{"byp_x5_held", 1, 64'hDEADBEEF_00000001});
        sb.push_back('{"byp_count_post", 2, 64'd3});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
    endtask

    task automatic test_regwrite_low();
        drive(1'b0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 5'd9);
        sb.push_back('{"rw0_pre_rd1", 0, 64'd0});
        sb.push_back('{"rw0_pre_rd2", 1, 64'd0});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
        sb.push_back('{"rw0_post_rd1", 0, 64'd0});
        sb.push_back('{"rw0_count", 2, 64'd3});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] widx;
        logic [4:0] r1;
        logic [4:0] r2;
        for (int n = 0; n < 80; n++) begin
            widx = 5'($urandom_range(0, 31));
            r1   = ($urandom_range(0, 3) == 0) ? widx : 5'($urandom_range(0, 31));
            r2   = ($urandom_range(0, 3) == 0) ? r1   : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 4) != 0), widx, {$urandom, $urandom}, r1, r2);
            sb.push_back('{"b2b_rd1", 0, exp_read(r1)});
            sb.push_back('{"b2b_rd2", 1, exp_read(r2)});
            sb.push_back('{"b2b_count", 2, {48'd0, model_count}});
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.sel);
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s n=%0d: got %h expected %h", e.name, n, obs, e.val);
                end
            end
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(i));
            sb.push_back('{"b2b_final_rd1", 0, model_regs[i]});
            sb.push_back('{"b2b_final_rd2", 1, model_regs[i]});
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.sel);
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s idx=%0d: got %h expected %h", e.name, i, obs, e.val);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 5'd3, 64'd111, 5'd0, 5'd0);
        tick();
        reset = 1'b1;
        drive(1'b1, 5'd3, 64'd64357, 5'd3, 5'd3);
        sb.push_back('{"rstpri_pre_rd1", 0, 64'd111});
        sb.push_back('{"rstpri_pre_rd2", 1, 64'd111});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
        sb.push_back('{"rstpri_in_rst_rd1", 0, 64'd0});
        sb.push_back('{"rstpri_in_rst_rd2", 1, 64'd0});
        sb.push_back('{"rstpri_count", 2, 64'd0});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        reset = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd7);
        sb.push_back('{"rstpri_x3", 0, 64'd0});
        sb.push_back('{"rstpri_x7", 1, 64'd0});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 5'd1, 64'(i), 5'd0, 5'd0);
            tick();
            if (i == 65534) begin
                drive(1'b0, 5'd1, 64'd0, 5'd1, 5'd1);
                sb.push_back('{"wrap_count_ffff", 2, 64'hFFFF});
                sb.push_back('{"wrap_x1_mid", 0, 64'd65534});
                @(negedge clk);
                while (sb.size() > 0) begin
                    e = sb.pop_front();
                    obs = observe(e.sel);
                    checks++;
                    if (obs !== e.val) begin
                        failures++;
                        $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
                    end
                end
            end
        end
        drive(1'b0, 5'd0, 64'd0, 5'd1, 5'd1);
        sb.push_back('{"wrap_count_zero", 2, 64'd0});
        sb.push_back('{"wrap_x1_rd1", 0, 64'd65535});
        sb.push_back('{"wrap_x1_rd2", 1, 64'd65535});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
        model_count = 16'd0;
        reset = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        @(negedge clk);
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_regwrite_low();
        test_back_to_back();
        test_reset_priority();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
